// File: rtl/commit_sequencer_pkg.sv
// Shared constants and types for the commit sequencer: branch count, commit id width,
// and the commit id type with its modulo-512 increment.
package commit_sequencer_pkg;

   localparam int N_INSTR_BRANCHES = 4;
   localparam int COMMIT_ID_WIDTH  = 9;

   typedef logic [COMMIT_ID_WIDTH-1:0] commit_id_t;

   // Commit ids wrap naturally at the type width (511 -> 0).
   function automatic commit_id_t next_id(input commit_id_t id);
      return id + commit_id_t'(1);
   endfunction

endpackage

// File: rtl/lowest_set_select.sv
// One-hot priority picker: keeps only the lowest-index set bit of the request vector.
module lowest_set_select #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_req,
   output logic [WIDTH-1:0] o_grant
);

   // Two's-complement trick: req & -req isolates the lowest set bit.
   assign o_grant = i_req & (~i_req + WIDTH'(1));

endmodule

// File: rtl/commit_sequencer.sv
// Releases branch results in strict commit id order through one registered writeback port.
// Optional sticky ordering-fault detector is built only with COMMIT_ORDER_CHECK_EN defined.
module commit_sequencer
   import commit_sequencer_pkg::*;
#(
   parameter int data_width = 16,
   parameter int n_blocks   = 256,
   parameter int n_branches = N_INSTR_BRANCHES
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  enable,
   input  logic                                  sample_tick,
   input  logic [n_branches-1:0]                 in_valid,
   output logic [n_branches-1:0]                 in_ready,
   input  logic [n_branches*COMMIT_ID_WIDTH-1:0] in_commit_id,
   input  logic [n_branches-1:0]                 in_commit_flag,
   input  logic [n_branches*$clog2(n_blocks)-1:0] in_block,
   input  logic [n_branches*4-1:0]               in_dest,
   input  logic [n_branches*data_width-1:0]      in_result,
   input  logic [n_branches-1:0]                 in_writes_external,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [$clog2(n_blocks)-1:0]           block_out,
   output logic [3:0]                            dest_out,
   output logic [data_width-1:0]                 result_out,
   output logic                                  writes_external_out,
   output logic [COMMIT_ID_WIDTH-1:0]            commit_id_out,
   output logic                                  busy,
   output logic                                  order_error
);

   localparam int BLK_W = $clog2(n_blocks);
   localparam int CW    = COMMIT_ID_WIDTH;

   commit_id_t              r_expected_id;
   logic                    r_out_valid;
   logic [BLK_W-1:0]        r_block;
   logic [3:0]              r_dest;
   logic [data_width-1:0]   r_result;
   logic                    r_ext;
   commit_id_t              r_commit_id;

   logic [n_branches-1:0]   w_match;
   logic [n_branches-1:0]   w_grant;
   logic                    w_out_free;
   logic                    w_accept;
   logic                    w_write;
   logic [BLK_W-1:0]        w_sel_block;
   logic [3:0]              w_sel_dest;
   logic [data_width-1:0]   w_sel_result;
   logic                    w_sel_ext;
   commit_id_t              w_sel_id;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_match = '0;
      for (int i = 0; i < n_branches; i++)
         w_match[i] = in_valid[i] & (in_commit_id[i*CW +: CW] == r_expected_id);
   end

   lowest_set_select #(.WIDTH(n_branches)) u_pick (
      .i_req   (w_match),
      .o_grant (w_grant)
   );

   assign w_out_free = ~r_out_valid | out_ready;

   // Silent retires never touch the output stage, so they need no output room.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < n_branches; i++)
         in_ready[i] = enable & w_grant[i] & (~in_commit_flag[i] | w_out_free);
   end

   assign w_accept = |in_ready;
   assign w_write  = |(in_ready & in_commit_flag);

   always_comb begin
      w_sel_block  = '0;
      w_sel_dest   = '0;
      w_sel_result = '0;
      w_sel_ext    = 1'b0;
      w_sel_id     = '0;
      for (int i = 0; i < n_branches; i++) begin
         if (w_grant[i]) begin
            w_sel_block  = in_block[i*BLK_W +: BLK_W];
            w_sel_dest   = in_dest[i*4 +: 4];
            w_sel_result = in_result[i*data_width +: data_width];
            w_sel_ext    = in_writes_external[i];
            w_sel_id     = in_commit_id[i*CW +: CW];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; reset clears the output stage
   // so a pending write is discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_expected_id <= '0;
         r_out_valid   <= 1'b0;
         r_block       <= '0;
         r_dest        <= '0;
         r_result      <= '0;
         r_ext         <= 1'b0;
         r_commit_id   <= '0;
      end else begin
         if (w_write) begin
            r_out_valid <= 1'b1;
            r_block     <= w_sel_block;
            r_dest      <= w_sel_dest;
            r_result    <= w_sel_result;
            r_ext       <= w_sel_ext;
            r_commit_id <= w_sel_id;
         end else if (enable && r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (sample_tick)
            r_expected_id <= '0;
         else if (w_accept)
            r_expected_id <= next_id(r_expected_id);
      end
   end

   assign out_valid           = r_out_valid;
   assign block_out           = r_block;
   assign dest_out            = r_dest;
   assign result_out          = r_result;
   assign writes_external_out = r_ext;
   assign commit_id_out       = r_commit_id;
   assign busy                = r_out_valid | (|in_valid);

`ifdef COMMIT_ORDER_CHECK_EN
   logic w_dup;
   logic w_stale;
   logic r_order_error;

   always_comb begin
      w_dup   = |(w_match & (w_match - n_branches'(1)));
      w_stale = 1'b0;
      for (int i = 0; i < n_branches; i++)
         w_stale = w_stale | (in_valid[i] & (in_commit_id[i*CW +: CW] < r_expected_id)
                              & (r_expected_id != '0));
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_order_error <= 1'b0;
      else if (w_dup || w_stale)
         r_order_error <= 1'b1;
   end

   assign order_error = r_order_error;
`else
   assign order_error = 1'b0;
`endif

endmodule

// File: tb/tb_commit_sequencer.sv
// Self-checking bench for commit_sequencer: a vector table for grant/ready behaviour plus
// hand-written multi-cycle sequences, with a write scoreboard checked at every output pop.
module tb_commit_sequencer;
   import commit_sequencer_pkg::*;

   localparam int NB = 4;
   localparam int DW = 16;

`ifdef COMMIT_ORDER_CHECK_EN
   localparam logic EXP_OE = 1'b1;
`else
   localparam logic EXP_OE = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            enable;
   logic            sample_tick;
   logic [NB-1:0]   in_valid;
   logic [NB-1:0]   in_ready;
   logic [NB*9-1:0] in_commit_id;
   logic [NB-1:0]   in_commit_flag;
   logic [NB*8-1:0] in_block;
   logic [NB*4-1:0] in_dest;
   logic [NB*DW-1:0] in_result;
   logic [NB-1:0]   in_writes_external;
   logic            out_valid;
   logic            out_ready;
   logic [7:0]      block_out;
   logic [3:0]      dest_out;
   logic [DW-1:0]   result_out;
   logic            writes_external_out;
   logic [8:0]      commit_id_out;
   logic            busy;
   logic            order_error;

   logic [8:0]      b_id [NB];

   commit_sequencer dut (
      .clk                 (clk),
      .reset               (reset),
      .enable              (enable),
      .sample_tick         (sample_tick),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_commit_id        (in_commit_id),
      .in_commit_flag      (in_commit_flag),
      .in_block            (in_block),
      .in_dest             (in_dest),
      .in_result           (in_result),
      .in_writes_external  (in_writes_external),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .block_out           (block_out),
      .dest_out            (dest_out),
      .result_out          (result_out),
      .writes_external_out (writes_external_out),
      .commit_id_out       (commit_id_out),
      .busy                (busy),
      .order_error         (order_error)
   );

   always #5 clk = ~clk;

   // Payload of each branch is a fixed function of (branch, id) so expectations are independent.
   function automatic logic [DW-1:0] res_fn(input int br, input logic [8:0] id);
      logic [3:0] b;
      b = br[3:0];
      return {b, 3'b101, id};
   endfunction
   function automatic logic [3:0] dest_fn(input int br, input logic [8:0] id);
      logic [3:0] b;
      b = br[3:0];
      return id[3:0] ^ b;
   endfunction
   function automatic logic [7:0] blk_fn(input int br, input logic [8:0] id);
      logic [3:0] b;
      b = br[3:0];
      return id[7:0] ^ 8'h5A ^ {b, 4'h0};
   endfunction
   function automatic logic ext_fn(input int br, input logic [8:0] id);
      logic [3:0] b;
      b = br[3:0];
      return id[0] ^ b[0];
   endfunction

   always_comb begin
      in_commit_id       = '0;
      in_block           = '0;
      in_dest            = '0;
      in_result          = '0;
      in_writes_external = '0;
      for (int i = 0; i < NB; i++) begin
         in_commit_id[i*9 +: 9]   = b_id[i];
         in_block[i*8 +: 8]       = blk_fn(i, b_id[i]);
         in_dest[i*4 +: 4]        = dest_fn(i, b_id[i]);
         in_result[i*DW +: DW]    = res_fn(i, b_id[i]);
         in_writes_external[i]    = ext_fn(i, b_id[i]);
      end
   end

   typedef struct {
      logic [8:0]    id;
      logic [DW-1:0] res;
      logic [3:0]    dest;
      logic [7:0]    blk;
      logic          ext;
   } wr_t;

   typedef struct {
      logic [3:0]      valid;
      logic [3:0]      flag;
      logic [3:0][8:0] ids;
      logic            ordy;
      logic            en;
      logic [3:0]      rdy;
   } vec_t;

   wr_t  sb_q [$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input int br, input logic [8:0] id);
      wr_t e;
      e.id   = id;
      e.res  = res_fn(br, id);
      e.dest = dest_fn(br, id);
      e.blk  = blk_fn(br, id);
      e.ext  = ext_fn(br, id);
      sb_q.push_back(e);
   endtask

   // One clock: optional in_ready check and scoreboard pop at negedge, then release accepted branches.
   task automatic tick(input bit chk, input logic [3:0] exp_rdy, input string nm);
      logic [3:0] acc;
      wr_t e;
      @(negedge clk);
      acc = in_ready;
      if (chk) check(nm, 32'(in_ready), 32'(exp_rdy));
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_write", 32'(commit_id_out), 32'h1FF);
         end else begin
            e = sb_q.pop_front();
            check("wr_id",   32'(commit_id_out),       32'(e.id));
            check("wr_res",  32'(result_out),          32'(e.res));
            check("wr_dest", 32'(dest_out),            32'(e.dest));
            check("wr_blk",  32'(block_out),           32'(e.blk));
            check("wr_ext",  32'(writes_external_out), 32'(e.ext));
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NB; i++)
         if (acc[i]) in_valid[i] = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && sb_q.size() > 0; k++) tick(1'b0, 4'b0, "");
      check("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      enable      = 1'b1;
      sample_tick = 1'b0;
      out_ready   = 1'b1;
      in_valid    = '0;
      in_commit_flag = '0;
      for (int i = 0; i < NB; i++) b_id[i] = '0;
      sb_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic present(input int br, input logic [8:0] id, input logic flag);
      in_valid[br]       = 1'b1;
      b_id[br]           = id;
      in_commit_flag[br] = flag;
   endtask

   function automatic vec_t mkv(input logic [3:0] valid, input logic [3:0] flag,
                                input logic [8:0] id3, input logic [8:0] id2,
                                input logic [8:0] id1, input logic [8:0] id0,
                                input logic ordy, input logic en, input logic [3:0] rdy);
      vec_t v;
      v.valid = valid;
      v.flag  = flag;
      v.ids   = {id3, id2, id1, id0};
      v.ordy  = ordy;
      v.en    = en;
      v.rdy   = rdy;
      return v;
   endfunction

   vec_t vecs [12];
   logic m_ov;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = mkv(4'b0001, 4'b1111, 0, 0, 0, 0, 1, 1, 4'b0001);
      vecs[1]  = mkv(4'b0110, 4'b1111, 0, 1, 1, 0, 1, 1, 4'b0010);
      vecs[2]  = mkv(4'b1100, 4'b1111, 2, 3, 0, 0, 1, 1, 4'b1000);
      vecs[3]  = mkv(4'b0100, 4'b0000, 0, 3, 0, 0, 1, 1, 4'b0100);
      vecs[4]  = mkv(4'b0001, 4'b1111, 0, 0, 0, 5, 1, 1, 4'b0000);
      vecs[5]  = mkv(4'b0001, 4'b1111, 0, 0, 0, 4, 1, 0, 4'b0000);
      vecs[6]  = mkv(4'b0001, 4'b1111, 0, 0, 0, 4, 1, 1, 4'b0001);
      vecs[7]  = mkv(4'b0010, 4'b1111, 0, 0, 5, 0, 0, 1, 4'b0000);
      vecs[8]  = mkv(4'b0010, 4'b0000, 0, 0, 5, 0, 0, 1, 4'b0010);
      vecs[9]  = mkv(4'b0001, 4'b1111, 0, 0, 0, 6, 1, 1, 4'b0001);
      vecs[10] = mkv(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 1, 4'b0000);
      vecs[11] = mkv(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 1, 4'b0000);

      // Reset state
      do_reset();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result",    32'(result_out), 32'd0);
      check("rst_id",        32'(commit_id_out), 32'd0);
      check("rst_dest",      32'(dest_out), 32'd0);
      check("rst_block",     32'(block_out), 32'd0);
      check("rst_ext",       32'(writes_external_out), 32'd0);
      check("rst_order_err", 32'(order_error), 32'd0);
      check("rst_busy",      32'(busy), 32'd0);

      // Vector table: grant priority, silent retire, stall, enable, backpressure
      m_ov = 1'b0;
      for (int r = 0; r < 12; r++) begin
         int idx;
         in_valid       = vecs[r].valid;
         in_commit_flag = vecs[r].flag;
         for (int i = 0; i < NB; i++) b_id[i] = vecs[r].ids[i];
         out_ready = vecs[r].ordy;
         enable    = vecs[r].en;
         idx = -1;
         for (int i = 0; i < NB; i++) if (vecs[r].rdy[i]) idx = i;
         if (idx >= 0 && vecs[r].flag[idx]) push(idx, vecs[r].ids[idx]);
         #1;
         check($sformatf("vec%0d_out_valid", r), 32'(out_valid), 32'(m_ov));
         check($sformatf("vec%0d_busy", r), 32'(busy), 32'(m_ov | (|vecs[r].valid)));
         tick(1'b1, vecs[r].rdy, $sformatf("vec%0d_ready", r));
         if (idx >= 0 && vecs[r].flag[idx]) m_ov = 1'b1;
         else if (vecs[r].en && vecs[r].ordy) m_ov = 1'b0;
      end
      check("vec_queue_empty", 32'(sb_q.size()), 32'd0);
      check("vec_order_err", 32'(order_error), 32'(EXP_OE));

      // Out-of-order finish: branch2 holds id1 until branch0 delivers id0
      do_reset();
      present(2, 9'd1, 1'b1);
      for (int c = 0; c < 3; c++) tick(1'b1, 4'b0000, "ooo_hold");
      present(0, 9'd0, 1'b1);
      push(0, 9'd0);
      push(2, 9'd1);
      tick(1'b1, 4'b0001, "ooo_b0");
      tick(1'b1, 4'b0100, "ooo_b2");
      drain();

      // Backpressure: output held, next id blocked, then pop and reload together
      do_reset();
      out_ready = 1'b0;
      present(0, 9'd0, 1'b1);
      push(0, 9'd0);
      tick(1'b1, 4'b0001, "bp_first");
      present(1, 9'd1, 1'b1);
      push(1, 9'd1);
      for (int c = 0; c < 3; c++) begin
         tick(1'b1, 4'b0000, "bp_hold_ready");
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_res", 32'(result_out), 32'(res_fn(0, 9'd0)));
         check("bp_hold_id", 32'(commit_id_out), 32'd0);
      end
      out_ready = 1'b1;
      tick(1'b1, 4'b0010, "bp_release");
      check("bp_reload_valid", 32'(out_valid), 32'd1);
      check("bp_reload_id", 32'(commit_id_out), 32'd1);
      drain();

      // sample_tick while expected id is 5
      do_reset();
      for (int k = 0; k < 5; k++) begin
         present(0, 9'(k), 1'b0);
         tick(1'b1, 4'b0001, "st_advance");
      end
      sample_tick = 1'b1;
      tick(1'b1, 4'b0000, "st_tick_idle");
      sample_tick = 1'b0;
      present(1, 9'd5, 1'b1);
      present(2, 9'd0, 1'b1);
      push(2, 9'd0);
      tick(1'b1, 4'b0100, "st_accept_id0");
      tick(1'b1, 4'b0000, "st_stall_id5");
      in_valid[1] = 1'b0;
      drain();

      // Reset mid-operation discards a pending write
      do_reset();
      out_ready = 1'b0;
      present(0, 9'd0, 1'b1);
      tick(1'b1, 4'b0001, "mid_accept");
      check("mid_pending", 32'(out_valid), 32'd1);
      do_reset();
      check("mid_discard", 32'(out_valid), 32'd0);

      // Duplicate id: two branches present id3 together
      do_reset();
      for (int k = 0; k < 3; k++) begin
         present(0, 9'(k), 1'b0);
         tick(1'b1, 4'b0001, "dup_advance");
      end
      check("dup_pre_err", 32'(order_error), 32'd0);
      present(0, 9'd3, 1'b0);
      present(1, 9'd3, 1'b0);
      tick(1'b1, 4'b0001, "dup_grant");
      check("dup_err_set", 32'(order_error), 32'(EXP_OE));
      in_valid[1] = 1'b0;
      for (int c = 0; c < 3; c++) tick(1'b0, 4'b0, "");
      check("dup_err_held", 32'(order_error), 32'(EXP_OE));
      do_reset();
      check("dup_err_cleared", 32'(order_error), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
